// File: rtl/ahblite_master.sv
// ahblite_master: single-channel AHB-Lite initiator.
// Turns a valid/ready command stream into AHB-Lite SINGLE transfers. One
// address phase (register A) is pipelined over one data phase (register D).
// Every accepted command produces exactly one response pulse, in command order.
//
// Handshake: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready never waits on cmd_valid. It does depend
// on the offered command's legality: a misaligned or size-3 command is only
// taken when nothing is in flight. Its immediate error response then cannot
// overtake the response of an older command. The response side has no
// backpressure: rsp_valid is a single-cycle pulse.
module ahblite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  // command stream
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response stream
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  // AHB-Lite master side
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [1:0]        HTRANS,
  output logic [DATA_W-1:0] HWDATA,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  // address-phase register A
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic              a_write;
  logic [1:0]        a_size;
  logic [DATA_W-1:0] a_wdata;

  // data-phase register D (its write data lives directly in HWDATA)
  logic              d_valid;
  logic              d_write;

  // a cancelled command's error response waiting behind the ERROR response
  logic              cancel_q;

  logic              cmd_legal;
  logic              err_first;
  logic              err_any;
  logic              pipe_empty;
  logic              ready_base;
  logic              accept;
  logic              d_done;

  // Classify the offered command and derive the acceptance condition.
  always_comb begin
    cmd_legal  = 1'b0;
    case (cmd_size)
      2'd0:    cmd_legal = 1'b1;
      2'd1:    cmd_legal = ~cmd_addr[0];
      2'd2:    cmd_legal = (cmd_addr[1:0] == 2'b00);
      default: cmd_legal = 1'b0;
    endcase
    err_any    = d_valid & HRESP;
    err_first  = err_any & ~HREADY;
    pipe_empty = ~a_valid & ~d_valid;
    ready_base = ~a_valid | (HREADY & ~err_any);
    // The first ERROR cycle and a queued cancel both block new commands.
    // Illegal commands additionally wait for an empty pipeline.
    cmd_ready  = ready_base & ~err_first & ~cancel_q & (cmd_legal | pipe_empty);
    accept     = cmd_valid & cmd_ready;
    d_done     = d_valid & HREADY;
  end

  // Bus outputs come straight from the A register so they hold while idle.
  always_comb begin
    HADDR     = a_addr;
    HWRITE    = a_write;
    HSIZE     = {1'b0, a_size};
    HTRANS    = a_valid ? TRANS_NONSEQ : TRANS_IDLE;
    HBURST    = 3'b000;
    HPROT     = 4'b0011;
    HMASTLOCK = 1'b0;
    busy      = a_valid | d_valid | cancel_q | rsp_valid;
  end

  // Pipeline advance, ERROR cancellation and ordered response generation.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      a_valid   <= 1'b0;
      a_addr    <= '0;
      a_write   <= 1'b0;
      a_size    <= 2'd0;
      a_wdata   <= '0;
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      HWDATA    <= '0;
      cancel_q  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      // Response slot: the completing data phase always wins. A queued cancel
      // follows it on the next cycle. An illegal command can only be taken
      // with nothing in flight, so it never competes with the other two.
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (d_done) begin
        rsp_valid <= 1'b1;
        rsp_err   <= HRESP;
        rsp_rdata <= d_write ? '0 : HRDATA;
      end else if (cancel_q) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        cancel_q  <= 1'b0;
      end else if (accept & ~cmd_legal) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
      end

      // Pipeline: HREADY high moves A into D. In the first ERROR cycle the
      // pending address phase is withdrawn. A plain wait state holds
      // everything, but an empty A may still be filled.
      if (HREADY) begin
        d_valid <= a_valid;
        d_write <= a_write;
        if (a_valid) begin
          HWDATA <= a_wdata;
        end
        a_valid <= accept & cmd_legal;
      end else if (err_first & a_valid) begin
        a_valid  <= 1'b0;
        cancel_q <= 1'b1;
      end else if (accept & cmd_legal) begin
        a_valid <= 1'b1;
      end

      if (accept & cmd_legal) begin
        a_addr  <= cmd_addr;
        a_write <= cmd_write;
        a_size  <= cmd_size;
        a_wdata <= cmd_wdata;
      end
    end
  end

endmodule

// File: doc/ahblite_master.md
# ahblite_master

Single-channel AHB-Lite initiator that turns a valid/ready command stream into AHB-Lite SINGLE transfers and returns one response per command. It sits between a command source (bench sequencer, DMA or debug bridge) and the AHBLITE_SYS interconnect, driving the bus the existing peripherals respond to. It pipelines one address phase over one data phase, honours HREADY wait states and performs the two-cycle ERROR response, cancelling the next pipelined transfer.

## Interface
- ADDR_W, 32, HADDR and cmd_addr width
- DATA_W, 32, data width; 32 is the only supported value
- CLK  in  1  bus clock; all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted on the edge where cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_size  in  2  HSIZE encoding: 0 = byte, 1 = half, 2 = word; 3 is illegal
- cmd_wdata  in  DATA_W  write data, already lane-aligned
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  DATA_W  captured HRDATA for reads, 0 for writes
- rsp_err  out  1  qualifies rsp_valid: bus ERROR, cancelled, or misaligned/illegal command
- busy  out  1  any address phase, data phase or response pending
- HADDR  out  ADDR_W; HWRITE out 1; HSIZE out 3; HTRANS out 2; HWDATA out DATA_W
- HBURST  out  3  constant 3'b000; HPROT out 4 constant 4'b0011; HMASTLOCK out 1 constant 0
- HRDATA  in  DATA_W; HREADY in 1 (system HREADY); HRESP in 1 (0 = OKAY, 1 = ERROR)

## Operation
- Pipeline registers: A (address phase: valid, addr, write, size, wdata) and D (data phase: valid, write, wdata).
- cmd_ready = !A.valid | (HREADY & !(HRESP & D.valid)). It is also forced 0 while an error or cancel response is queued.
- On accept:
  - Aligned command: A loads; the next cycle drives HTRANS=NONSEQ (2'b10), HADDR, HWRITE, HSIZE={1'b0,cmd_size}.
  - Misaligned command (half with addr[0]=1, word with addr[1:0]≠0) or size 3: never issued; HTRANS stays IDLE; response with rsp_err=1 the next cycle.
- HTRANS=IDLE (2'b00) whenever A is empty. HADDR, HWRITE and HSIZE hold their last value when idle.
- Edge with HREADY=1: D completes and A moves to D (HWDATA <= A.wdata). A reloads from a new command or clears.
- Edge with HREADY=0 and HRESP=0: all pipeline state holds and bus outputs are stable (wait state).
- ERROR, first cycle (HRESP=1, HREADY=0):
  - If A is valid, the next cycle drives HTRANS=IDLE, clears A and queues a cancel response.
  - No new command is accepted.
- ERROR, second cycle (HRESP=1, HREADY=1): D completes with rsp_err=1.
- Responses are strictly in command order. After an ERROR, the erroring transfer's response comes first and the cancelled command's response (rsp_err=1, rdata 0) follows in the next cycle.
- Read response: rsp_rdata = HRDATA sampled on the completing edge. Write response: rsp_rdata = 0.
- busy = A.valid | D.valid | queued response | rsp_valid.

## Timing
- Reset state: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, A and D empty. cmd_ready=1 in the first cycle after RESET falls.
- Latency for a command accepted at edge N with zero wait states:
  - Address phase is cycle N+1.
  - Data phase is cycle N+2 (HWDATA valid).
  - rsp_valid is high in cycle N+3.
- Each wait cycle adds 1 cycle to latency.
- Back-to-back commands with zero wait states give one transfer per cycle: NONSEQ on consecutive cycles and a rsp_valid pulse every cycle.
- Misaligned command accepted at edge N: rsp_valid=1 and rsp_err=1 in cycle N+1.
- RESET asserted mid-transfer: all state clears immediately (asynchronous). No response is emitted for in-flight commands.

## Test plan
- Single write 0x5000_0000 ← 0x0000_00A5, size 2, HREADY=1 -> NONSEQ at N+1, HWDATA=0xA5 at N+2, rsp_valid at N+3 with rsp_err=0.
- Read 0x5000_0000 with slave HREADY low for 3 data-phase cycles, HRDATA=0x1234_5678 -> address held stable, rsp_valid at N+6 with rsp_rdata=0x1234_5678.
- Four back-to-back writes 0x0,0x4,0x8,0xC, HREADY=1 -> NONSEQ on 4 consecutive cycles, 4 consecutive rsp_valid pulses with rsp_err=0.
- Write to 0x4 followed by read of 0x8; slave returns ERROR for 0x4 -> HTRANS=IDLE in the second ERROR cycle, read 0x8 never reaches a data phase; responses are err=1 (write), then err=1 (cancelled read) on the next cycle.
- Word command to 0x2 and size=3 command -> no NONSEQ driven, each returns rsp_err=1 one cycle after accept.
- RESET pulsed during a wait-stated read -> HTRANS=00, rsp_valid=0 and busy=0 immediately; cmd_ready=1 after release.
